acc_subword_unpacker: RTL

Receive-side counterpart of the precision-scalable PE adder.
- Accepts one packed accumulator word per handshake.
- Splits it into its 4-bit or 2-bit subword lanes, or passes a full-precision word through unchanged.
- Sign- or zero-extends each lane and emits one lane per output handshake.
- Sits between the PE array accumulator readout and the requantization/output-buffer path.

---
 rtl/acc_subword_unpacker_pkg.sv | 36 +++
 rtl/subword_extract.sv | 35 +++
 rtl/acc_subword_unpacker.sv | 108 ++++++++++
 3 files changed

// File: rtl/acc_subword_unpacker_pkg.sv
// Shared types and helpers for the accumulator subword unpacker.
// Holds the precision-mode encoding, FSM states and default widths.
package acc_subword_unpacker_pkg;

    localparam int ACC_DATA_WIDTH = 32;
    localparam int ACT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        MODE_FULL = 3'b100,
        MODE_4B   = 3'b010,
        MODE_2B   = 3'b001
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Any encoding other than the two subword modes is handled as full precision.
    function automatic mode_e decode_mode(input logic [2:0] raw);
        case (raw)
            3'b010:  return MODE_4B;
            3'b001:  return MODE_2B;
            default: return MODE_FULL;
        endcase
    endfunction

    function automatic logic [1:0] last_lane(input mode_e mode);
        case (mode)
            MODE_4B: return 2'd1;
            MODE_2B: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/subword_extract.sv
// Combinational lane selector: picks one 4-bit or 2-bit field of the packed
// word (or the whole word in full mode) and sign- or zero-extends it.
module subword_extract
    import acc_subword_unpacker_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = acc_subword_unpacker_pkg::ACC_DATA_WIDTH,
    parameter int ACT_DATA_WIDTH = acc_subword_unpacker_pkg::ACT_DATA_WIDTH
) (
    input  logic [ACC_DATA_WIDTH-1:0] word,
    input  mode_e                     mode,
    input  logic [1:0]                lane,
    input  logic                      is_signed,
    output logic [ACC_DATA_WIDTH-1:0] lane_data
);

    logic [ACT_DATA_WIDTH-1:0] act;
    logic [3:0]                nibble;
    logic [1:0]                crumb;

    assign act    = word[ACT_DATA_WIDTH-1:0];
    assign nibble = act[{lane[0], 2'b00} +: 4];
    assign crumb  = act[{lane, 1'b0} +: 2];

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        lane_data = word;
        case (mode)
            MODE_4B: lane_data = {{(ACC_DATA_WIDTH-4){is_signed & nibble[3]}}, nibble};
            MODE_2B: lane_data = {{(ACC_DATA_WIDTH-2){is_signed & crumb[1]}}, crumb};
            default: lane_data = word;
        endcase
    end

endmodule

// File: rtl/acc_subword_unpacker.sv
// Unpacks one accumulator word per input handshake into 1, 2 or 4 extended
// lanes, one per output handshake, with fully registered outputs.
module acc_subword_unpacker
    import acc_subword_unpacker_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = acc_subword_unpacker_pkg::ACC_DATA_WIDTH,
    parameter int ACT_DATA_WIDTH = acc_subword_unpacker_pkg::ACT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ACC_DATA_WIDTH-1:0] in_data,
    input  logic [2:0]                in_mode,
    input  logic                      in_signed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_DATA_WIDTH-1:0] out_data,
    output logic [1:0]                out_lane,
    output logic                      out_last
);

    state_e                    state;
    logic [ACC_DATA_WIDTH-1:0] held_data;
    mode_e                     held_mode;
    logic                      held_signed;
    logic [1:0]                lane_cnt;

    logic                      take;
    logic                      out_fire;
    logic [1:0]                next_lane;
    mode_e                     in_mode_dec;

    logic [ACC_DATA_WIDTH-1:0] ext_word;
    mode_e                     ext_mode;
    logic [1:0]                ext_lane;
    logic                      ext_signed;
    logic [ACC_DATA_WIDTH-1:0] ext_data;

    // The last lane being accepted frees the slot, so a full-mode stream runs at one word per cycle.
    assign in_ready    = reset_n && ((state == IDLE) || (out_valid && out_ready && out_last));
    assign take        = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign next_lane   = lane_cnt + 2'd1;
    assign in_mode_dec = decode_mode(in_mode);
    assign out_lane    = lane_cnt;

    // One extractor serves both the incoming word's lane 0 and the held word's next lane.
    always_comb begin
        ext_word   = held_data;
        ext_mode   = held_mode;
        ext_lane   = next_lane;
        ext_signed = held_signed;
        if (take) begin
            ext_word   = in_data;
            ext_mode   = in_mode_dec;
            ext_lane   = 2'd0;
            ext_signed = in_signed;
        end
    end

    subword_extract #(
        .ACC_DATA_WIDTH (ACC_DATA_WIDTH),
        .ACT_DATA_WIDTH (ACT_DATA_WIDTH)
    ) u_extract (
        .word      (ext_word),
        .mode      (ext_mode),
        .lane      (ext_lane),
        .is_signed (ext_signed),
        .lane_data (ext_data)
    );

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the held word is a plain register, not a memory, so it is
            // cleared on reset along with the control state.
            state       <= IDLE;
            held_data   <= '0;
            held_mode   <= MODE_FULL;
            held_signed <= 1'b0;
            lane_cnt    <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else if (take) begin
            state       <= EMIT;
            held_data   <= in_data;
            held_mode   <= in_mode_dec;
            held_signed <= in_signed;
            lane_cnt    <= 2'd0;
            out_valid   <= 1'b1;
            out_data    <= ext_data;
            out_last    <= (last_lane(in_mode_dec) == 2'd0);
        end else if (out_fire) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                lane_cnt <= next_lane;
                out_data <= ext_data;
                out_last <= (next_lane == last_lane(held_mode));
            end
        end
    end

endmodule
